// File: rtl/mem_load_unit_if.sv
// Load request, data-memory read port and write-back response bundle for mem_load_unit.
// slave = the load unit itself, master = the MEM stage / memory / write-back side driving it.
interface mem_load_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [2:0]  req_func3;
  logic        mem_re;
  logic [12:0] mem_addr;
  logic [63:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_addr, req_func3, mem_rdata, rsp_ready,
    output req_ready, mem_re, mem_addr, rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_func3, mem_rdata, rsp_ready,
    input  req_ready, mem_re, mem_addr, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/mem_load_unit.sv
// Aligned load unit: 1-cycle sync-read memory, byte/half/word/dword extract + extend, 3 cycles per load
// (error loads 2, no memory access); response held in RESP until rsp_ready, no new accept meanwhile.
module mem_load_unit (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  mem_load_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  off_q, off_d;
  logic [2:0]  func3_q, func3_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        mem_re;
  logic        aligned;
  logic [63:0] shifted;
  logic [63:0] ext;
  logic        unused_addr_bits;

  // Only the low 16 address bits reach the 8K-doubleword memory.
  assign unused_addr_bits = ^bus.req_addr[63:16];

  always_comb begin
    aligned = 1'b0;
    case (bus.req_func3)
      3'b000, 3'b100: aligned = 1'b1;
      3'b001, 3'b101: aligned = ~bus.req_addr[0];
      3'b010, 3'b110: aligned = (bus.req_addr[1:0] == 2'b00);
      3'b011:         aligned = (bus.req_addr[2:0] == 3'b000);
      default:        aligned = 1'b0;
    endcase
  end

  assign shifted = bus.mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ext = shifted;
    case (func3_q)
      3'b000:  ext = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  ext = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  ext = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  ext = {56'd0, shifted[7:0]};
      3'b101:  ext = {48'd0, shifted[15:0]};
      3'b110:  ext = {32'd0, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    func3_d    = func3_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    mem_re     = 1'b0;
    // Flush wins over everything, including an acceptance or a returning read.
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            if (aligned) begin
              mem_re  = 1'b1;
              off_d   = bus.req_addr[2:0];
              func3_d = bus.req_func3;
              state_d = READ;
            end else begin
              rsp_data_d = 64'd0;
              rsp_err_d  = 1'b1;
              state_d    = RESP;
            end
          end
        end
        READ: begin
          rsp_data_d = ext;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end
        RESP: begin
          if (bus.rsp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      off_q      <= 3'd0;
      func3_q    <= 3'd0;
      rsp_data_q <= 64'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      func3_q    <= func3_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_re    = mem_re;
  assign bus.mem_addr  = bus.req_addr[15:3];
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit: behavioural 1-cycle memory, hand-computed load results.
module tb_mem_load_unit;
  logic clk;
  logic rst_n;
  logic flush;
  int   tests;
  int   fails;

  mem_load_unit_if mif ();

  mem_load_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] WORD = 64'h8877_6655_4433_2211;

  // Synchronous-read memory: only doubleword 0x20 holds data.
  always @(posedge clk) begin
    if (mif.mem_re)
      mif.mem_rdata <= (mif.mem_addr == 13'h020) ? WORD : 64'h0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One load, response taken on the first valid cycle.
  task automatic do_load(input string tag, input logic [63:0] addr, input logic [2:0] f3,
                         input logic [63:0] exp_data, input logic exp_err);
    int cyc;
    @(negedge clk);
    mif.req_valid = 1'b1;
    mif.req_addr  = addr;
    mif.req_func3 = f3;
    #1;
    check({tag, " req_ready"}, {63'd0, mif.req_ready}, 64'd1);
    check({tag, " mem_re"},    {63'd0, mif.mem_re},    {63'd0, ~exp_err});
    check({tag, " mem_addr"},  {51'd0, mif.mem_addr},  {51'd0, addr[15:3]});
    @(negedge clk);
    mif.req_valid = 1'b0;
    cyc = 1;
    while (!mif.rsp_valid && cyc < 6) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"},  64'(cyc), exp_err ? 64'd1 : 64'd2);
    check({tag, " rsp_data"}, mif.rsp_data, exp_data);
    check({tag, " rsp_err"},  {63'd0, mif.rsp_err}, {63'd0, exp_err});
    mif.rsp_ready = 1'b1;
    @(negedge clk);
    mif.rsp_ready = 1'b0;
    check({tag, " handoff valid"}, {63'd0, mif.rsp_valid}, 64'd0);
    check({tag, " handoff ready"}, {63'd0, mif.req_ready}, 64'd1);
  endtask

  initial begin
    int cyc;
    tests         = 0;
    fails         = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    mif.req_valid = 1'b0;
    mif.req_addr  = 64'd0;
    mif.req_func3 = 3'd0;
    mif.rsp_ready = 1'b0;
    mif.mem_rdata = 64'd0;
    repeat (3) @(negedge clk);
    check("reset rsp_valid", {63'd0, mif.rsp_valid}, 64'd0);
    check("reset rsp_data",  mif.rsp_data, 64'd0);
    check("reset rsp_err",   {63'd0, mif.rsp_err}, 64'd0);
    check("reset req_ready", {63'd0, mif.req_ready}, 64'd1);
    check("reset mem_re",    {63'd0, mif.mem_re}, 64'd0);
    rst_n = 1'b1;

    // rsp_ready while idle is harmless
    @(negedge clk);
    mif.rsp_ready = 1'b1;
    @(negedge clk);
    mif.rsp_ready = 1'b0;
    check("idle rsp_ready", {63'd0, mif.rsp_valid}, 64'd0);

    do_load("lb 103",  64'h103, 3'b000, 64'h0000_0000_0000_0044, 1'b0);
    do_load("lb 107",  64'h107, 3'b000, 64'hFFFF_FFFF_FFFF_FF88, 1'b0);
    do_load("lbu 107", 64'h107, 3'b100, 64'h0000_0000_0000_0088, 1'b0);
    do_load("lh 106",  64'h106, 3'b001, 64'hFFFF_FFFF_FFFF_8877, 1'b0);
    do_load("lhu 102", 64'h102, 3'b101, 64'h0000_0000_0000_4433, 1'b0);
    do_load("lw 104",  64'h104, 3'b010, 64'hFFFF_FFFF_8877_6655, 1'b0);
    do_load("lwu 104", 64'h104, 3'b110, 64'h0000_0000_8877_6655, 1'b0);
    do_load("ld 100",  64'h100, 3'b011, 64'h8877_6655_4433_2211, 1'b0);
    do_load("lw 102 misal", 64'h102, 3'b010, 64'd0, 1'b1);
    do_load("lh 101 misal", 64'h101, 3'b001, 64'd0, 1'b1);
    do_load("ld 104 misal", 64'h104, 3'b011, 64'd0, 1'b1);
    do_load("f3 111",       64'h100, 3'b111, 64'd0, 1'b1);

    // Backpressure: response held for 3 cycles while a new request waits.
    @(negedge clk);
    mif.req_valid = 1'b1;
    mif.req_addr  = 64'h103;
    mif.req_func3 = 3'b000;
    @(negedge clk);
    mif.req_addr  = 64'h100;
    mif.req_func3 = 3'b011;
    @(negedge clk);
    check("bp valid", {63'd0, mif.rsp_valid}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp hold valid", {63'd0, mif.rsp_valid}, 64'd1);
      check("bp hold data",  mif.rsp_data, 64'h44);
      check("bp hold err",   {63'd0, mif.rsp_err}, 64'd0);
      check("bp req_ready",  {63'd0, mif.req_ready}, 64'd0);
      check("bp mem_re",     {63'd0, mif.mem_re}, 64'd0);
    end
    mif.req_valid = 1'b0;
    mif.rsp_ready = 1'b1;
    @(negedge clk);
    mif.rsp_ready = 1'b0;
    check("bp release valid", {63'd0, mif.rsp_valid}, 64'd0);
    check("bp release ready", {63'd0, mif.req_ready}, 64'd1);

    // Flush during READ.
    @(negedge clk);
    mif.req_valid = 1'b1;
    mif.req_addr  = 64'h104;
    mif.req_func3 = 3'b010;
    @(negedge clk);
    mif.req_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush read ready", {63'd0, mif.req_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      check("flush read no rsp", {63'd0, mif.rsp_valid}, 64'd0);
      @(negedge clk);
    end

    // Flush during RESP.
    mif.req_valid = 1'b1;
    mif.req_addr  = 64'h107;
    mif.req_func3 = 3'b000;
    @(negedge clk);
    mif.req_valid = 1'b0;
    @(negedge clk);
    check("flush resp pre valid", {63'd0, mif.rsp_valid}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush resp valid", {63'd0, mif.rsp_valid}, 64'd0);
    check("flush resp ready", {63'd0, mif.req_ready}, 64'd1);

    // Flush in IDLE blocks a concurrent request.
    mif.req_valid = 1'b1;
    mif.req_addr  = 64'h100;
    mif.req_func3 = 3'b011;
    flush = 1'b1;
    #1;
    check("flush idle mem_re", {63'd0, mif.mem_re}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    mif.req_valid = 1'b0;
    check("flush idle ready", {63'd0, mif.req_ready}, 64'd1);
    @(negedge clk);
    check("flush idle no rsp", {63'd0, mif.rsp_valid}, 64'd0);

    do_load("lbu 100", 64'h100, 3'b100, 64'h11, 1'b0);

    // Reset pulse during READ.
    @(negedge clk);
    mif.req_valid = 1'b1;
    mif.req_addr  = 64'h104;
    mif.req_func3 = 3'b010;
    @(negedge clk);
    mif.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst rsp_data",  mif.rsp_data, 64'd0);
    check("rst rsp_err",   {63'd0, mif.rsp_err}, 64'd0);
    check("rst rsp_valid", {63'd0, mif.rsp_valid}, 64'd0);
    check("rst req_ready", {63'd0, mif.req_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    repeat (3) begin
      @(negedge clk);
      if (mif.rsp_valid) cyc++;
    end
    check("rst late data ignored", 64'(cyc), 64'd0);
    check("rst data stays zero", mif.rsp_data, 64'd0);

    do_load("ld after rst", 64'h100, 3'b011, 64'h8877_6655_4433_2211, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
